// File: rtl/des_block_scheduler.sv
// Two-requester round-robin scheduler feeding a single DES core through setup/launch/wait/respond/ack phases.
// Optional WAIT watchdog enabled by defining DES_SCHED_TIMEOUT_EN.
module des_block_scheduler #(
  parameter int SETUP_CYCLES   = 3,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        req0_valid,
  input  logic        req1_valid,
  input  logic [63:0] req0_data,
  input  logic [63:0] req1_data,
  input  logic        req0_encrypt,
  input  logic        req1_encrypt,
  output logic        req0_ready,
  output logic        req1_ready,
  output logic        rsp0_valid,
  output logic        rsp1_valid,
  input  logic        rsp0_ack,
  input  logic        rsp1_ack,
  output logic [63:0] rsp_data,
  output logic [63:0] core_rcv_data,
  output logic        core_rcv_data_ready,
  output logic        core_encrypt,
  output logic        core_handshake_ack,
  input  logic [63:0] core_trans_data,
  input  logic        core_trans_data_ready,
  output logic        busy,
  output logic        err_timeout
);

  if (SETUP_CYCLES < 2 || SETUP_CYCLES > 15 || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_param
    $error("des_block_scheduler: parameter out of range");
  end

  localparam logic [3:0] SETUP_LAST = 4'(SETUP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_LAUNCH,
    S_WAIT,
    S_RESP,
    S_ACK
  } state_t;

  state_t      state_q, state_d;
  logic        grant_q, grant_d;
  logic        prio_q, prio_d;
  logic [63:0] blk_q, blk_d;
  logic        enc_q, enc_d;
  logic [63:0] rsp_data_q, rsp_data_d;
  logic [3:0]  setup_cnt_q, setup_cnt_d;
  logic        pick1;
  logic        ack_sel;

`ifdef DES_SCHED_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0]  tmo_cnt_q, tmo_cnt_d;
  logic        err_q, err_d;
`endif

  always_comb begin
    state_d             = state_q;
    grant_d             = grant_q;
    prio_d              = prio_q;
    blk_d               = blk_q;
    enc_d               = enc_q;
    rsp_data_d          = rsp_data_q;
    setup_cnt_d         = setup_cnt_q;
    pick1               = 1'b0;
    ack_sel             = 1'b0;
    req0_ready          = 1'b0;
    req1_ready          = 1'b0;
    rsp0_valid          = 1'b0;
    rsp1_valid          = 1'b0;
    core_rcv_data_ready = 1'b0;
    core_handshake_ack  = 1'b0;
`ifdef DES_SCHED_TIMEOUT_EN
    tmo_cnt_d           = tmo_cnt_q;
    err_d               = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        // A lone requester wins outright; the pointer only breaks ties.
        if (req0_valid || req1_valid) begin
          pick1       = req1_valid && (!req0_valid || prio_q);
          grant_d     = pick1;
          req0_ready  = !pick1;
          req1_ready  = pick1;
          blk_d       = pick1 ? req1_data : req0_data;
          enc_d       = pick1 ? req1_encrypt : req0_encrypt;
          setup_cnt_d = 4'd0;
          state_d     = S_SETUP;
        end
      end
      S_SETUP: begin
        if (setup_cnt_q == SETUP_LAST) begin
          setup_cnt_d = 4'd0;
          state_d     = S_LAUNCH;
        end else begin
          setup_cnt_d = setup_cnt_q + 4'd1;
        end
      end
      S_LAUNCH: begin
        core_rcv_data_ready = 1'b1;
        state_d             = S_WAIT;
`ifdef DES_SCHED_TIMEOUT_EN
        tmo_cnt_d           = 8'd0;
`endif
      end
      S_WAIT: begin
        if (core_trans_data_ready) begin
          rsp_data_d = core_trans_data;
          state_d    = S_RESP;
        end
`ifdef DES_SCHED_TIMEOUT_EN
        // Abandon the block and still flush the core through ACK.
        else if (tmo_cnt_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = S_ACK;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
`endif
      end
      S_RESP: begin
        rsp0_valid = !grant_q;
        rsp1_valid = grant_q;
        ack_sel    = grant_q ? rsp1_ack : rsp0_ack;
        if (ack_sel) begin
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        core_handshake_ack = 1'b1;
        prio_d             = !prio_q;
        state_d            = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= S_IDLE;
      grant_q     <= 1'b0;
      prio_q      <= 1'b0;
      blk_q       <= 64'd0;
      enc_q       <= 1'b0;
      rsp_data_q  <= 64'd0;
      setup_cnt_q <= 4'd0;
`ifdef DES_SCHED_TIMEOUT_EN
      tmo_cnt_q   <= 8'd0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      prio_q      <= prio_d;
      blk_q       <= blk_d;
      enc_q       <= enc_d;
      rsp_data_q  <= rsp_data_d;
      setup_cnt_q <= setup_cnt_d;
`ifdef DES_SCHED_TIMEOUT_EN
      tmo_cnt_q   <= tmo_cnt_d;
      err_q       <= err_d;
`endif
    end
  end

  assign core_rcv_data = blk_q;
  assign core_encrypt  = enc_q;
  assign rsp_data      = rsp_data_q;
  assign busy          = (state_q != S_IDLE);
`ifdef DES_SCHED_TIMEOUT_EN
  assign err_timeout   = err_q;
`else
  assign err_timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_des_block_scheduler.sv
// Directed bench for des_block_scheduler: table of transactions plus reset-abort and watchdog sequences.
module tb_des_block_scheduler;
  localparam int SETUP = 3;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        req0_valid, req1_valid;
  logic [63:0] req0_data, req1_data;
  logic        req0_encrypt, req1_encrypt;
  logic        req0_ready, req1_ready;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ack, rsp1_ack;
  logic [63:0] rsp_data;
  logic [63:0] core_rcv_data;
  logic        core_rcv_data_ready, core_encrypt, core_handshake_ack;
  logic [63:0] core_trans_data;
  logic        core_trans_data_ready;
  logic        busy, err_timeout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  des_block_scheduler #(.SETUP_CYCLES(SETUP), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .n_rst(n_rst),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_data(req0_data), .req1_data(req1_data),
    .req0_encrypt(req0_encrypt), .req1_encrypt(req1_encrypt),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp0_ack(rsp0_ack), .rsp1_ack(rsp1_ack),
    .rsp_data(rsp_data),
    .core_rcv_data(core_rcv_data), .core_rcv_data_ready(core_rcv_data_ready),
    .core_encrypt(core_encrypt), .core_handshake_ack(core_handshake_ack),
    .core_trans_data(core_trans_data), .core_trans_data_ready(core_trans_data_ready),
    .busy(busy), .err_timeout(err_timeout)
  );

  typedef struct {
    logic        v0;
    logic        v1;
    logic [63:0] d0;
    logic [63:0] d1;
    logic        e0;
    logic        e1;
    logic        gnt;
    int          lat;
    int          hold;
  } vec_t;

  vec_t tbl [9];

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Stand-in for the DES core transform; any bijection works for routing checks.
  function automatic logic [63:0] core_f(input logic [63:0] d, input logic e);
    return e ? (d ^ 64'hF0E1D2C3B4A59687) : {d[31:0], d[63:32]};
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk1({tag, "_req0_ready"}, req0_ready, 1'b0);
    chk1({tag, "_req1_ready"}, req1_ready, 1'b0);
    chk1({tag, "_rsp0_valid"}, rsp0_valid, 1'b0);
    chk1({tag, "_rsp1_valid"}, rsp1_valid, 1'b0);
    chk1({tag, "_rcv_ready"}, core_rcv_data_ready, 1'b0);
    chk1({tag, "_hs_ack"}, core_handshake_ack, 1'b0);
    chk1({tag, "_encrypt"}, core_encrypt, 1'b0);
    chk1({tag, "_busy"}, busy, 1'b0);
    chk1({tag, "_err"}, err_timeout, 1'b0);
    chk64({tag, "_rsp_data"}, rsp_data, 64'd0);
    chk64({tag, "_rcv_data"}, core_rcv_data, 64'd0);
  endtask

  task automatic run_txn(input vec_t v);
    logic [63:0] exp_blk;
    logic        exp_enc;
    logic [63:0] exp_rsp;
    exp_blk = v.gnt ? v.d1 : v.d0;
    exp_enc = v.gnt ? v.e1 : v.e0;
    exp_rsp = core_f(exp_blk, exp_enc);
    @(negedge clk);
    req0_valid = v.v0; req1_valid = v.v1;
    req0_data = v.d0; req1_data = v.d1;
    req0_encrypt = v.e0; req1_encrypt = v.e1;
    #1;
    chk1("grant_req0_ready", req0_ready, !v.gnt);
    chk1("grant_req1_ready", req1_ready, v.gnt);
    chk1("grant_busy", busy, 1'b0);
    @(negedge clk);
    req0_data = ~v.d0; req1_data = ~v.d1;
    req0_encrypt = ~v.e0; req1_encrypt = ~v.e1;
    for (int i = 0; i < SETUP; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      chk64("setup_rcv_data", core_rcv_data, exp_blk);
      chk1("setup_encrypt", core_encrypt, exp_enc);
      chk1("setup_rcv_ready", core_rcv_data_ready, 1'b0);
      chk1("setup_req_ready", req0_ready | req1_ready, 1'b0);
      chk1("setup_busy", busy, 1'b1);
    end
    @(negedge clk); #1;
    chk1("launch_rcv_ready", core_rcv_data_ready, 1'b1);
    chk64("launch_rcv_data", core_rcv_data, exp_blk);
    for (int i = 0; i < v.lat; i++) begin
      @(negedge clk); #1;
      chk1("wait_rcv_ready", core_rcv_data_ready, 1'b0);
      chk1("wait_rsp_valid", rsp0_valid | rsp1_valid, 1'b0);
    end
    core_trans_data = core_f(core_rcv_data, core_encrypt);
    core_trans_data_ready = 1'b1;
    @(negedge clk);
    core_trans_data_ready = 1'b0;
    core_trans_data = '1;
    #1;
    chk1("resp_rsp0_valid", rsp0_valid, !v.gnt);
    chk1("resp_rsp1_valid", rsp1_valid, v.gnt);
    chk64("resp_rsp_data", rsp_data, exp_rsp);
    for (int i = 0; i < v.hold; i++) begin
      if (v.gnt) rsp0_ack = (i % 2 == 0);
      else rsp1_ack = (i % 2 == 0);
      @(negedge clk); #1;
      chk1("hold_rsp_valid", v.gnt ? rsp1_valid : rsp0_valid, 1'b1);
      chk1("hold_hs_ack", core_handshake_ack, 1'b0);
      chk1("hold_core_encrypt", core_encrypt, exp_enc);
    end
    rsp0_ack = !v.gnt; rsp1_ack = v.gnt;
    @(negedge clk); #1;
    chk1("ack_hs_ack", core_handshake_ack, 1'b1);
    chk1("ack_rsp_valid", rsp0_valid | rsp1_valid, 1'b0);
    chk1("ack_no_grant", req0_ready | req1_ready, 1'b0);
    chk64("ack_rsp_data_held", rsp_data, exp_rsp);
    chk64("ack_rcv_data_held", core_rcv_data, exp_blk);
    rsp0_ack = 1'b0; rsp1_ack = 1'b0;
  endtask

  initial begin
    vec_t post;
    n_rst = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_data = '0; req1_data = '0;
    req0_encrypt = 1'b0; req1_encrypt = 1'b0;
    rsp0_ack = 1'b0; rsp1_ack = 1'b0;
    core_trans_data = '0; core_trans_data_ready = 1'b0;

    tbl[0] = '{1'b1, 1'b0, 64'h0123456789ABCDEF, 64'h0, 1'b1, 1'b0, 1'b0, 2, 0};
    tbl[1] = '{1'b1, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'h0, 1'b0, 1'b0, 1'b0, 1, 0};
    tbl[2] = '{1'b1, 1'b1, 64'h1111111111111111, 64'h2222222222222222, 1'b1, 1'b0, 1'b0, 3, 0};
    tbl[3] = '{1'b1, 1'b1, 64'h3333333333333333, 64'h4444444444444444, 1'b0, 1'b1, 1'b1, 1, 0};
    tbl[4] = '{1'b1, 1'b1, 64'h5555555555555555, 64'h6666666666666666, 1'b0, 1'b0, 1'b0, 2, 0};
    tbl[5] = '{1'b1, 1'b1, 64'h7777777777777777, 64'h8888888888888888, 1'b1, 1'b1, 1'b1, 1, 0};
    tbl[6] = '{1'b0, 1'b1, 64'h0, 64'hDEADBEEFCAFEF00D, 1'b0, 1'b1, 1'b1, 4, 3};
    tbl[7] = '{1'b1, 1'b0, 64'h0000000000000000, 64'h0, 1'b0, 1'b0, 1'b0, 1, 10};
    tbl[8] = '{1'b0, 1'b1, 64'h0, 64'h8000000000000001, 1'b0, 1'b0, 1'b1, 2, 0};

    #12;
    check_reset_outputs("por");
    @(negedge clk);
    n_rst = 1'b1;

    for (int k = 0; k < 9; k++) run_txn(tbl[k]);

    // Pointer now favours requester 1; abort in the 5th WAIT cycle.
    @(negedge clk);
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_data = 64'hAAAAAAAAAAAAAAAA; req1_data = 64'h5555AAAA5555AAAA;
    req0_encrypt = 1'b0; req1_encrypt = 1'b1;
    #1;
    chk1("rst_pre_req1_ready", req1_ready, 1'b1);
    chk1("rst_pre_req0_ready", req0_ready, 1'b0);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (8) @(negedge clk);
    #1;
    chk1("rst_pre_busy", busy, 1'b1);
    chk64("rst_pre_rcv_data", core_rcv_data, 64'h5555AAAA5555AAAA);
    #1 n_rst = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    @(negedge clk);
    n_rst = 1'b1;
    post = '{1'b1, 1'b1, 64'h0F0F0F0F0F0F0F0F, 64'hF0F0F0F0F0F0F0F0, 1'b1, 1'b0, 1'b0, 2, 0};
    run_txn(post);

`ifdef DES_SCHED_TIMEOUT_EN
    @(negedge clk);
    req0_valid = 1'b1; req1_valid = 1'b0;
    req0_data = 64'h1234567812345678; req0_encrypt = 1'b1;
    #1;
    chk1("tmo_grant", req0_ready, 1'b1);
    @(negedge clk);
    req0_valid = 1'b0;
    repeat (SETUP) @(negedge clk);
    #1;
    chk1("tmo_launch", core_rcv_data_ready, 1'b1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #1;
      chk1("tmo_wait_err", err_timeout, 1'b0);
      chk1("tmo_wait_busy", busy, 1'b1);
      chk1("tmo_wait_hs", core_handshake_ack, 1'b0);
    end
    @(negedge clk); #1;
    chk1("tmo_ack_hs", core_handshake_ack, 1'b1);
    chk1("tmo_ack_err", err_timeout, 1'b1);
    chk1("tmo_ack_rsp_valid", rsp0_valid | rsp1_valid, 1'b0);
    @(negedge clk); #1;
    chk1("tmo_idle_busy", busy, 1'b0);
    chk1("tmo_idle_hs", core_handshake_ack, 1'b0);
    chk1("tmo_idle_err_sticky", err_timeout, 1'b1);
    chk1("tmo_idle_rsp_valid", rsp0_valid | rsp1_valid, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/des_block_scheduler.md
DES_BLOCK_SCHEDULER -- requirements
Module: des_block_scheduler

Interface
REQ-001 SHALL have parameter SETUP_CYCLES, default 3, cycles core_encrypt is held stable before the launch pulse (range 2..15).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 64, maximum WAIT cycles before abort (range 2..255; used only with DES_SCHED_TIMEOUT_EN).
REQ-003 SHALL have port clk  in  1  system clock, all state on rising edge.
REQ-004 SHALL have port n_rst  in  1  asynchronous active-low reset.
REQ-005 SHALL have ports req0_valid / req1_valid  in  1  requester has a 64-bit block pending.
REQ-006 SHALL have ports req0_data / req1_data  in  64  block to process.
REQ-007 SHALL have ports req0_encrypt / req1_encrypt  in  1  1 = encrypt, 0 = decrypt.
REQ-008 SHALL have ports req0_ready / req1_ready  out  1  one-cycle accept strobe.
REQ-009 SHALL have ports rsp0_valid / rsp1_valid  out  1  result available to that requester.
REQ-010 SHALL have ports rsp0_ack / rsp1_ack  in  1  requester consumed result.
REQ-011 SHALL have port rsp_data  out  64  result block, shared by both requesters.
REQ-012 SHALL have ports core_rcv_data (out 64), core_rcv_data_ready (out 1), core_encrypt (out 1), core_handshake_ack (out 1), core_trans_data (in 64), core_trans_data_ready (in 1) driving the DES encryptor core.
REQ-013 SHALL have ports busy (out 1, state != IDLE) and err_timeout (out 1, sticky abort flag).

Function
REQ-014 SHALL implement states IDLE, SETUP, LAUNCH, WAIT, RESP, ACK.
REQ-015 IDLE: if any req_valid, grant one requester, pulse its req_ready for exactly one cycle, capture its data/encrypt into internal registers, and go to SETUP.
REQ-016 Arbitration SHALL be round-robin: after reset requester 0 has priority; the pointer moves to the other requester on every ACK exit.
REQ-017 If only one requester is valid, it SHALL be granted regardless of the pointer.
REQ-018 core_rcv_data and core_encrypt SHALL be driven from the captured registers and held constant from SETUP entry through ACK.
REQ-019 SETUP SHALL last exactly SETUP_CYCLES cycles, then go to LAUNCH.
REQ-020 LAUNCH SHALL assert core_rcv_data_ready for exactly one cycle, then go to WAIT.
REQ-021 WAIT: on core_trans_data_ready = 1, SHALL capture core_trans_data into rsp_data and go to RESP the next cycle.
REQ-022 RESP SHALL hold rsp_valid of the granted requester high, and only that one, until its rsp_ack = 1, then go to ACK; the other requester's rsp_ack SHALL be ignored.
REQ-023 ACK SHALL assert core_handshake_ack for exactly one cycle, then go to IDLE; a new grant SHALL NOT occur before the following cycle.
REQ-024 req_valid falling before req_ready SHALL leave no state effect; req_valid changes after grant SHALL be ignored.
REQ-025 rsp_data SHALL hold its value after RESP until the next WAIT capture.
REQ-026 Minimum grant-to-ACK latency SHALL be SETUP_CYCLES + 1 + core latency + 1 + 1 (rsp_ack already high) cycles.

Reset
REQ-027 On n_rst = 0, the block SHALL immediately enter IDLE, from any state, including mid-WAIT.
REQ-028 Reset values SHALL be: all ready/valid/ack/strobe outputs 0; busy 0; err_timeout 0; rsp_data, core_rcv_data, and core_encrypt all 0; priority pointer at requester 0; all counters 0.

Configuration
REQ-029 With DES_SCHED_TIMEOUT_EN defined, WAIT SHALL count cycles, and on reaching TIMEOUT_CYCLES without core_trans_data_ready it SHALL set err_timeout, drop the block with no rsp_valid, and go to ACK (core flush).
REQ-030 err_timeout SHALL clear only on reset.
REQ-031 Without DES_SCHED_TIMEOUT_EN, WAIT SHALL wait indefinitely, the timeout counter SHALL not exist, and err_timeout SHALL be tied 0.

Verification
REQ-032 Reset, then req0 with data 0x0123456789ABCDEF and encrypt = 1 -> req0_ready at cycle 1, core_encrypt = 1 for 3 cycles, one-cycle core_rcv_data_ready, then rsp0_valid with rsp_data = core_trans_data.
REQ-033 req0 and req1 both valid continuously for 4 blocks -> grants in order 0, 1, 0, 1.
REQ-034 rsp0_ack held 0 for 10 cycles, rsp1_ack pulsed during that time -> rsp0_valid stays high, no core_handshake_ack until rsp0_ack = 1.
REQ-035 n_rst asserted in the 5th cycle of WAIT -> all outputs return to reset values asynchronously; the next request starts at requester 0.
REQ-036 With DES_SCHED_TIMEOUT_EN and TIMEOUT_CYCLES = 8, core never responds -> err_timeout = 1 after 8 WAIT cycles, no rsp_valid, one core_handshake_ack pulse, then IDLE.
